// File: rtl/muldiv_sequencer.sv
// Control sequencer for an iterative MULTU/DIVU unit.
// Walks IDLE -> LOAD -> RUN (STEPS iterations) -> WRITE and drives the datapath strobes.
// Optional build macro: MULDIV_DIVU_EN (when defined, DIVU is accepted and reported as op_sel=10).
// Handshake: start is sampled on a rising edge only while idle with a legal funct;
// any start seen while busy is dropped, and stall holds the front end meanwhile.
module muldiv_sequencer #(
    parameter int STEPS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] funct,
    input  logic       mf_req,
    output logic       busy,
    output logic       ld,
    output logic       step,
    output logic [5:0] step_cnt,
    output logic [1:0] op_sel,
    output logic       hilo_we,
    output logic       done,
    output logic       stall,
    output logic [1:0] o_dbg_state
);

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] LAST    = 6'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_op_sel;
    logic [5:0] r_step_cnt;
    logic [1:0] w_req_op;
    logic       w_accept;

    // Decode funct into an operation code; 00 marks an unsupported funct.
    always_comb begin
        w_req_op = 2'b00;
        if (funct == F_MULTU) begin
            w_req_op = 2'b01;
        end
`ifdef MULDIV_DIVU_EN
        else if (funct == F_DIVU) begin
            w_req_op = 2'b10;
        end
`else
        else if (funct == F_DIVU) begin
            w_req_op = 2'b00;
        end
`endif
    end

    assign w_accept = (r_state == S_IDLE) && start && (w_req_op != 2'b00);

    // Next-state logic: one LOAD cycle, STEPS RUN cycles, one WRITE cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_LOAD;
            S_LOAD:  w_next = S_RUN;
            S_RUN:   if (r_step_cnt == LAST) w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Operation code captured on acceptance, cleared as the unit returns to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_op_sel <= 2'b00;
        else if (w_accept)           r_op_sel <= w_req_op;
        else if (r_state == S_WRITE) r_op_sel <= 2'b00;
    end

    // Iteration index: counts during RUN, saturates at STEPS-1, cleared leaving WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_cnt <= 6'd0;
        end else if (r_state == S_RUN) begin
            if (r_step_cnt != LAST) r_step_cnt <= r_step_cnt + 6'd1;
        end else if (r_state == S_WRITE) begin
            r_step_cnt <= 6'd0;
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign ld          = (r_state == S_LOAD);
    assign step        = (r_state == S_RUN);
    assign hilo_we     = (r_state == S_WRITE);
    assign done        = (r_state == S_WRITE);
    assign step_cnt    = r_step_cnt;
    assign op_sel      = r_op_sel;
    assign stall       = busy & (mf_req | start);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed scenarios plus random traffic,
// checked against a cycle-offset reference model and a completion scoreboard.
module tb_muldiv_sequencer;

  localparam int STEPS = 32;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam int W = 34;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] funct = 6'd0;
  logic       mf_req = 1'b0;
  logic       busy, ld, step, hilo_we, done, stall;
  logic [5:0] step_cnt;
  logic [1:0] op_sel;
  logic [1:0] dbg_state;

  muldiv_sequencer #(.STEPS(STEPS)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .mf_req(mf_req),
    .busy(busy), .ld(ld), .step(step), .step_cnt(step_cnt), .op_sel(op_sel),
    .hilo_we(hilo_we), .done(done), .stall(stall), .o_dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: an accepted operation is described only by its acceptance edge
  int         edge_n = 0;
  bit         m_valid = 1'b0;
  int         m_acc = 0;
  logic [1:0] m_op = 2'b00;
  logic [W-1:0] exp_q[$];

  function automatic logic [1:0] ref_op(input logic [5:0] f);
    if (f == F_MULTU) return 2'b01;
`ifdef MULDIV_DIVU_EN
    if (f == F_DIVU) return 2'b10;
`endif
    return 2'b00;
  endfunction

  // offset of the current cycle from the acceptance edge, -1 when idle
  function automatic int phase_at(input int e);
    int k;
    if (!m_valid) return -1;
    k = e - m_acc;
    if (k < 0 || k > STEPS + 1) return -1;
    return k;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // model update on each rising edge: accept only if the cycle just ending was idle
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (!rst && start && ref_op(funct) != 2'b00 && phase_at(edge_n - 1) < 0) begin
      m_valid = 1'b1;
      m_acc   = edge_n;
      m_op    = ref_op(funct);
      exp_q.push_back({m_op, 32'(edge_n + STEPS + 1)});
    end
  end

  // monitor: per-cycle output check and completion scoreboard
  always @(negedge clk) begin
    int k;
    logic e_busy, e_ld, e_step, e_we, e_stall;
    logic [1:0] e_op;
    logic [5:0] e_cnt;
    logic [W-1:0] exp_v;
    k = phase_at(edge_n);
    e_busy  = (k >= 0);
    e_ld    = (k == 0);
    e_step  = (k >= 1 && k <= STEPS);
    e_we    = (k == STEPS + 1);
    e_op    = e_busy ? m_op : 2'b00;
    e_stall = e_busy & (mf_req | start);
    e_cnt   = e_step ? 6'(k - 1) : 6'd0;
    check("outputs", W'({busy, ld, step, hilo_we, done, op_sel, stall}),
          W'({e_busy, e_ld, e_step, e_we, e_we, e_op, e_stall}));
    if (e_we) check("step_cnt_sat", W'(step_cnt <= 6'(STEPS - 1)), W'(1'b1));
    else      check("step_cnt", W'(step_cnt), W'(e_cnt));
    if (hilo_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_hilo_we", W'(1'b1), W'(1'b0));
      end else begin
        exp_v = exp_q.pop_front();
        check("completion", {op_sel, 32'(edge_n)}, exp_v);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic s, input logic [5:0] f, input logic m);
    @(posedge clk);
    #2;
    start  = s;
    funct  = f;
    mf_req = m;
  endtask

  task automatic idle_n(input int n);
    repeat (n) drive(1'b0, 6'd0, 1'b0);
  endtask

  // asynchronous reset pulse asserted between edges (call just after an edge)
  task automatic reset_mid();
    #1;
    rst = 1'b1;
    m_valid = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset", W'({busy, ld, step, hilo_we, done, stall, op_sel, step_cnt}), W'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int found;
    logic [5:0] f;
    // reset values, then start presented for the first edge after release
    repeat (2) @(posedge clk);
    #2;
    check("reset_values", W'({busy, ld, step, hilo_we, done, stall, op_sel, step_cnt}), W'(0));
    start = 1'b1; funct = F_MULTU; rst = 1'b0;
    idle_n(STEPS + 4);

    // repeated start during the run is ignored and raises stall
    drive(1'b1, F_MULTU, 1'b0);
    idle_n(9);
    drive(1'b1, F_MULTU, 1'b0);
    idle_n(STEPS);

    // pending MFHI/MFLO throughout an operation
    drive(1'b1, F_MULTU, 1'b1);
    repeat (STEPS + 4) drive(1'b0, 6'd0, 1'b1);
    idle_n(2);

    // reset during RUN with step_cnt = 17
    drive(1'b1, F_MULTU, 1'b0);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 6'd0, 1'b0);
      if (phase_at(edge_n) == 18) begin
        found = 1;
        break;
      end
    end
    check("reach_step17", W'(found), W'(1));
    check("step_cnt_before_reset", W'(step_cnt), W'(6'd17));
    reset_mid();
    idle_n(4);

    // unsupported funct is ignored
    drive(1'b1, F_ADD, 1'b0);
    idle_n(4);

    // DIVU: full sequence with the option, ignored without it
    drive(1'b1, F_DIVU, 1'b0);
    idle_n(STEPS + 4);

    // start held high: each new operation is accepted in the first idle cycle
    repeat (2 * (STEPS + 3) + 4) drive(1'b1, F_MULTU, 1'b0);
    idle_n(STEPS + 4);

    // random traffic with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: f = F_MULTU;
        1: f = F_DIVU;
        2: f = F_ADD;
        default: f = 6'($urandom_range(0, 63));
      endcase
      drive(($urandom_range(0, 5) == 0), f, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 299) == 0) reset_mid();
    end
    idle_n(STEPS + 4);

    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
